branch_resolve_unit: RTL and testbench

- Execute-stage consumer of the branch comparator outputs (br_less, br_equal); also drives the comparator's br_unsigned select.
- Decides the branch/jump outcome, checks it against the IF-stage direction prediction, and issues a registered PC redirect plus flushes of IF/ID and ID/EX.
- Owns the bimodal branch history table (2-bit saturating counters), read by IF and updated here on every resolved conditional branch.

---
 rtl/branch_resolve_unit.sv | 131 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution with bimodal BHT, registered redirect/flush and perf counters.
// Latency: redirect/flush/illegal registered one cycle after resolution; BHT read combinational.
// Backpressure: stall_i holds EX unresolved; a redirect cycle squashes the wrong-path EX slot.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             ex_valid_i,
    input  logic             ex_is_branch_i,
    input  logic             ex_is_jal_i,
    input  logic             ex_is_jalr_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_imm_i,
    input  logic [XLEN-1:0]  ex_rs1_i,
    input  logic             ex_pred_taken_i,
    input  logic             br_less_i,
    input  logic             br_equal_i,
    output logic             br_unsigned_o,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             if_pred_taken_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic             illegal_br_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    typedef enum logic {S_IDLE, S_REDIRECT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        bht [BHT_ENTRIES];
    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic              sel_jalr, sel_jal, sel_br;
    logic              br_illegal, br_taken, res;
    logic              redirect_now, bht_upd, illegal_now;
    logic [XLEN-1:0]   redirect_tgt;
    logic [1:0]        cnt_old, cnt_new;
    logic              unused_pc_bits;

    assign if_idx          = if_pc_i[IDX_W+1:2];
    assign ex_idx          = ex_pc_i[IDX_W+1:2];
    assign if_pred_taken_o = bht[if_idx][1];
    assign br_unsigned_o   = ex_funct3_i[1];
    assign unused_pc_bits  = ^{if_pc_i[XLEN-1:IDX_W+2], if_pc_i[1:0]};

    always_comb begin
        sel_jalr     = ex_is_jalr_i;
        sel_jal      = ex_is_jal_i & ~ex_is_jalr_i;
        sel_br       = ex_is_branch_i & ~ex_is_jal_i & ~ex_is_jalr_i;
        br_illegal   = (ex_funct3_i[2:1] == 2'b01);
        res          = ex_valid_i & ~stall_i & (state == S_IDLE);

        unique case (ex_funct3_i)
            3'b000:         br_taken = br_equal_i;
            3'b001:         br_taken = ~br_equal_i;
            3'b100, 3'b110: br_taken = br_less_i;
            3'b101, 3'b111: br_taken = ~br_less_i;
            default:        br_taken = 1'b0;
        endcase

        redirect_now = 1'b0;
        redirect_tgt = ex_pc_i + ex_imm_i;
        if (sel_jalr) begin
            redirect_now = res;
            redirect_tgt = (ex_rs1_i + ex_imm_i) & ALIGN_MASK;
        end else if (sel_jal) begin
            redirect_now = res;
        end else if (sel_br) begin
            redirect_now = res & (br_taken != ex_pred_taken_i);
            if (!br_taken)
                redirect_tgt = ex_pc_i + XLEN'(4);
        end

        illegal_now = res & sel_br & br_illegal;
        bht_upd     = res & sel_br & ~br_illegal;

        // Saturating 2-bit counter step toward the resolved direction.
        cnt_old = bht[ex_idx];
        cnt_new = cnt_old;
        if (br_taken && cnt_old != 2'b11)
            cnt_new = cnt_old + 2'd1;
        else if (!br_taken && cnt_old != 2'b00)
            cnt_new = cnt_old - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (redirect_now) state_nxt = S_REDIRECT;
            S_REDIRECT: state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_o          <= 1'b0;
            illegal_br_o     <= 1'b0;
            branch_cnt_o     <= '0;
            mispred_cnt_o    <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++)
                bht[i] <= 2'b01;
        end else begin
            state            <= state_nxt;
            redirect_valid_o <= redirect_now;
            flush_o          <= redirect_now;
            illegal_br_o     <= illegal_now;
            if (redirect_now) begin
                redirect_pc_o <= redirect_tgt;
                mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
            end
            if (res && sel_br)
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            if (bht_upd)
                bht[ex_idx] <= cnt_new;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed, table-driven bench for branch_resolve_unit plus hand-written multi-cycle sequences.
module tb_branch_resolve_unit;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, ex_valid_i, ex_is_branch_i, ex_is_jal_i, ex_is_jalr_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i, ex_imm_i, ex_rs1_i, if_pc_i;
    logic        ex_pred_taken_i, br_less_i, br_equal_i;
    logic        br_unsigned_o, if_pred_taken_o, redirect_valid_o, flush_o, illegal_br_o;
    logic [31:0] redirect_pc_o, branch_cnt_o, mispred_cnt_o;

    branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
        .ex_is_branch_i(ex_is_branch_i), .ex_is_jal_i(ex_is_jal_i), .ex_is_jalr_i(ex_is_jalr_i),
        .ex_funct3_i(ex_funct3_i), .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .ex_rs1_i(ex_rs1_i),
        .ex_pred_taken_i(ex_pred_taken_i), .br_less_i(br_less_i), .br_equal_i(br_equal_i),
        .br_unsigned_o(br_unsigned_o), .if_pc_i(if_pc_i), .if_pred_taken_o(if_pred_taken_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
        .illegal_br_o(illegal_br_o), .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] pc, imm, rs1;
        logic        pred, less, eq;
        logic        exp_uns, exp_redir;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int          tests = 0, fails = 0;
    logic [31:0] exp_bcnt = 0, exp_mcnt = 0, exp_last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 0; ex_valid_i = 0; ex_is_branch_i = 0; ex_is_jal_i = 0; ex_is_jalr_i = 0;
        ex_funct3_i = 3'b000; ex_pc_i = 0; ex_imm_i = 0; ex_rs1_i = 0;
        ex_pred_taken_i = 0; br_less_i = 0; br_equal_i = 0;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                            input logic pred, input logic less, input logic eq);
        ex_valid_i = 1; ex_is_branch_i = 1; ex_is_jal_i = 0; ex_is_jalr_i = 0;
        ex_funct3_i = f3; ex_pc_i = pc; ex_imm_i = imm; ex_rs1_i = 0;
        ex_pred_taken_i = pred; br_less_i = less; br_equal_i = eq;
    endtask

    // One BHT update on pc 0x14 with a correct prediction; checks the read before and after the edge.
    task automatic bht_step(input logic taken, input logic exp_before, input logic exp_after);
        drive_br(3'b000, 32'h14, 32'h40, taken, 1'b0, taken);
        if_pc_i = 32'h14;
        #1;
        chk("bht_same_cycle_read", {31'b0, if_pred_taken_o}, {31'b0, exp_before});
        tick();
        chk("bht_after_update", {31'b0, if_pred_taken_o}, {31'b0, exp_after});
        chk("bht_no_redirect", {31'b0, redirect_valid_o}, 32'h0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_branch_cnt"}, branch_cnt_o, exp_bcnt);
        chk({tag, "_mispred_cnt"}, mispred_cnt_o, exp_mcnt);
    endtask

    initial begin
        //           br jal jalr f3      pc          imm          rs1         pred less eq  uns redir exp_pc       ill
        vecs[0] = '{1, 0, 0, 3'b100, 32'h100, 32'h20,       32'h0,    0, 1, 0, 0, 1, 32'h120,  0};
        vecs[1] = '{1, 0, 0, 3'b111, 32'h300, 32'h10,       32'h0,    1, 0, 0, 1, 0, 32'h0,    0};
        vecs[2] = '{1, 0, 0, 3'b001, 32'h200, 32'h40,       32'h0,    1, 0, 1, 0, 1, 32'h204,  0};
        vecs[3] = '{0, 0, 1, 3'b000, 32'h80,  32'h4,        32'h1003, 0, 0, 0, 0, 1, 32'h1006, 0};
        vecs[4] = '{0, 1, 0, 3'b000, 32'h40,  32'hFFFFFFF8, 32'h0,    0, 0, 0, 0, 1, 32'h38,   0};
        vecs[5] = '{1, 0, 0, 3'b010, 32'h400, 32'h20,       32'h0,    0, 1, 1, 1, 0, 32'h0,    1};
        vecs[6] = '{1, 0, 0, 3'b000, 32'h500, 32'h100,      32'h0,    0, 0, 1, 0, 1, 32'h600,  0};
        vecs[7] = '{1, 0, 0, 3'b101, 32'h600, 32'h20,       32'h0,    0, 1, 0, 0, 0, 32'h0,    0};
        vecs[8] = '{0, 1, 1, 3'b000, 32'h700, 32'h11,       32'h2000, 0, 0, 0, 0, 1, 32'h2010, 0};
        vecs[9] = '{1, 0, 0, 3'b110, 32'h800, 32'h8,        32'h0,    1, 0, 0, 1, 1, 32'h804,  0};

        idle_inputs();
        if_pc_i = 32'h100;
        rst_i = 1;
        tick(); tick();
        rst_i = 0;
        chk("rst_redirect_valid", {31'b0, redirect_valid_o}, 32'h0);
        chk("rst_redirect_pc", redirect_pc_o, 32'h0);
        chk("rst_flush", {31'b0, flush_o}, 32'h0);
        chk("rst_illegal", {31'b0, illegal_br_o}, 32'h0);
        chk_counters("rst");
        chk("rst_bht_pred", {31'b0, if_pred_taken_o}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            ex_valid_i = 1; ex_is_branch_i = vecs[i].br; ex_is_jal_i = vecs[i].jal;
            ex_is_jalr_i = vecs[i].jalr; ex_funct3_i = vecs[i].f3; ex_pc_i = vecs[i].pc;
            ex_imm_i = vecs[i].imm; ex_rs1_i = vecs[i].rs1; ex_pred_taken_i = vecs[i].pred;
            br_less_i = vecs[i].less; br_equal_i = vecs[i].eq;
            #1;
            chk($sformatf("v%0d_br_unsigned", i), {31'b0, br_unsigned_o}, {31'b0, vecs[i].exp_uns});
            tick();
            if (vecs[i].exp_redir) begin
                exp_mcnt++;
                exp_last = vecs[i].exp_pc;
            end
            if (vecs[i].br && !vecs[i].jal && !vecs[i].jalr) exp_bcnt++;
            chk($sformatf("v%0d_redirect_valid", i), {31'b0, redirect_valid_o}, {31'b0, vecs[i].exp_redir});
            chk($sformatf("v%0d_flush", i), {31'b0, flush_o}, {31'b0, vecs[i].exp_redir});
            chk($sformatf("v%0d_redirect_pc", i), redirect_pc_o, exp_last);
            chk($sformatf("v%0d_illegal", i), {31'b0, illegal_br_o}, {31'b0, vecs[i].exp_ill});
            chk_counters($sformatf("v%0d", i));
            idle_inputs();
            tick();
            chk($sformatf("v%0d_redirect_drop", i), {31'b0, redirect_valid_o}, 32'h0);
            chk($sformatf("v%0d_illegal_drop", i), {31'b0, illegal_br_o}, 32'h0);
        end

        // BLT at 0x100 updated its index (idx 0) from 01 to 10, then aliasing branches moved it on;
        // a fresh check of the first test-plan case follows the reset below.

        // Wrong-path squash: mispredicted BNE, then a would-be redirecting BEQ in the REDIRECT cycle.
        drive_br(3'b001, 32'h200, 32'h40, 1'b1, 1'b0, 1'b1);
        tick();
        exp_bcnt++; exp_mcnt++;
        chk("wp_first_redirect", {31'b0, redirect_valid_o}, 32'h1);
        chk("wp_first_pc", redirect_pc_o, 32'h204);
        drive_br(3'b000, 32'h300, 32'h80, 1'b0, 1'b0, 1'b1);
        tick();
        chk("wp_no_second_redirect", {31'b0, redirect_valid_o}, 32'h0);
        chk("wp_pc_held", redirect_pc_o, 32'h204);
        chk_counters("wp");
        idle_inputs();
        tick();

        // Fresh reset, then the first test-plan case with a BHT check on idx(0x100).
        rst_i = 1;
        tick();
        rst_i = 0;
        exp_bcnt = 0; exp_mcnt = 0;
        if_pc_i = 32'h100;
        drive_br(3'b100, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0);
        tick();
        exp_bcnt++; exp_mcnt++;
        chk("blt_redirect_pc", redirect_pc_o, 32'h120);
        chk("blt_bht_now_10", {31'b0, if_pred_taken_o}, 32'h1);
        chk_counters("blt");
        idle_inputs();
        tick();

        // Saturation on idx 5: four taken, four not-taken, then two taken.
        bht_step(1, 0, 1); bht_step(1, 1, 1); bht_step(1, 1, 1); bht_step(1, 1, 1);
        bht_step(0, 1, 1); bht_step(0, 1, 0); bht_step(0, 0, 0); bht_step(0, 0, 0);
        bht_step(1, 0, 0); bht_step(1, 0, 1);
        exp_bcnt += 10;
        chk_counters("sat");
        idle_inputs();

        // Stall holds a mispredicting branch unresolved until it drops.
        stall_i = 1;
        drive_br(3'b100, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0);
        stall_i = 1;
        tick();
        chk("stall_no_redirect_1", {31'b0, redirect_valid_o}, 32'h0);
        tick();
        chk("stall_no_redirect_2", {31'b0, redirect_valid_o}, 32'h0);
        chk_counters("stall");
        stall_i = 0;
        tick();
        exp_bcnt++; exp_mcnt++;
        chk("stall_release_redirect", {31'b0, redirect_valid_o}, 32'h1);
        chk("stall_release_pc", redirect_pc_o, 32'h120);
        chk_counters("stall_release");
        idle_inputs();
        tick();

        // Reset while in REDIRECT: everything clears and idx 5 (state 10) returns to 01.
        ex_valid_i = 1; ex_is_jal_i = 1; ex_pc_i = 32'h40; ex_imm_i = 32'h8;
        tick();
        chk("rr_redirect_before", {31'b0, redirect_valid_o}, 32'h1);
        idle_inputs();
        if_pc_i = 32'h14;
        #1;
        chk("rr_bht_before", {31'b0, if_pred_taken_o}, 32'h1);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("rr_redirect_valid", {31'b0, redirect_valid_o}, 32'h0);
        chk("rr_flush", {31'b0, flush_o}, 32'h0);
        chk("rr_redirect_pc", redirect_pc_o, 32'h0);
        exp_bcnt = 0; exp_mcnt = 0;
        chk_counters("rr");
        chk("rr_bht_reset", {31'b0, if_pred_taken_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
